// File: rtl/serial_mod5_pkg.sv
// serial_mod5_pkg
//   Shared types and helpers for the mod-5 serial check link.
//   rem_t       : running remainder of the bit stream value modulo 5
//   tx_state_t  : frame FSM states of the transmitter
//   next_rem    : remainder after appending one bit, (2*r + b) % 5
//   check_bits  : 3-bit check value C that makes (X*8 + C) % 5 == 0,
//                 given r = X % 5 (C = 2*r % 5)
package serial_mod5_pkg;

  localparam int CHK_W = 3;

  typedef enum logic [2:0] {
    MOD0 = 3'd0,
    MOD1 = 3'd1,
    MOD2 = 3'd2,
    MOD3 = 3'd3,
    MOD4 = 3'd4
  } rem_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } tx_state_t;

  // Encodings 5..7 cannot occur; they collapse to MOD0 so the logic stays total.
  function automatic rem_t next_rem(input rem_t r, input logic b);
    rem_t n;
    case (r)
      MOD0:    n = b ? MOD1 : MOD0;
      MOD1:    n = b ? MOD3 : MOD2;
      MOD2:    n = b ? MOD0 : MOD4;
      MOD3:    n = b ? MOD2 : MOD1;
      MOD4:    n = b ? MOD4 : MOD3;
      default: n = MOD0;
    endcase
    return n;
  endfunction

  // Appending three bits multiplies by 8 (== 3 mod 5); C must cancel 3*r,
  // so C == 2*r (mod 5).
  function automatic logic [CHK_W-1:0] check_bits(input rem_t r);
    logic [CHK_W-1:0] c;
    case (r)
      MOD0:    c = 3'd0;
      MOD1:    c = 3'd2;
      MOD2:    c = 3'd4;
      MOD3:    c = 3'd1;
      MOD4:    c = 3'd3;
      default: c = 3'd0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mod5_remainder_tracker.sv
// mod5_remainder_tracker
//   Holds the running remainder (mod 5) of an MSB-first bit stream.
//   Usable on both the transmit and receive side of the link.
// Ports
//   clk      clock
//   rst      synchronous active-high reset, remainder -> MOD0
//   clr      restart the remainder at MOD0 (start of a new frame)
//   advance  fold bit_in into the remainder this cycle
//   bit_in   next stream bit
//   rem      current remainder
module mod5_remainder_tracker
  import serial_mod5_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic advance,
  input  logic bit_in,
  output rem_t rem
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rem <= MOD0;
    end else if (advance) begin
      rem <= next_rem(rem, bit_in);
    end
  end

endmodule

// File: rtl/serial_mod5_check_transmitter.sv
// serial_mod5_check_transmitter
//   Serializes a DATA_W-bit word MSB-first, one bit per out handshake, then
//   appends a 3-bit check value so the whole frame is divisible by 5.
//   Optional build macro SERIAL_MOD5_TX_FRAME_CNT_EN adds a 16-bit count of
//   completed frames (out_last handshakes), wrapping at 16'hFFFF.
// Ports
//   clk        clock
//   rst        synchronous active-high reset
//   in_valid   payload word offered
//   in_ready   word can be accepted (IDLE and not in reset)
//   in_data    payload word
//   out_valid  out_bit is valid
//   out_ready  sink takes out_bit this cycle
//   out_bit    serial bit, MSB-first
//   out_first  out_bit is the first payload bit of a frame
//   out_last   out_bit is the final check bit of a frame
//   frame_cnt  (macro only) completed-frame counter
module serial_mod5_check_transmitter
  import serial_mod5_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic              out_first,
  output logic              out_last
`ifdef SERIAL_MOD5_TX_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  localparam int CNT_W = ($clog2(DATA_W) > 2) ? $clog2(DATA_W) : 2;

  tx_state_t         state_reg, state_next;
  logic [DATA_W-1:0] shreg_reg, shreg_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [CHK_W-1:0]  chk_reg, chk_next;
  logic              first_reg, first_next;

  logic rem_clr;
  logic rem_advance;
  rem_t rem;
  logic handshake;

  mod5_remainder_tracker u_rem (
    .clk     (clk),
    .rst     (rst),
    .clr     (rem_clr),
    .advance (rem_advance),
    .bit_in  (out_bit),
    .rem     (rem)
  );

  // Outputs are decoded from registered state only, so they hold while stalled.
  always_comb begin
    in_ready  = (state_reg == IDLE) && !rst;
    out_valid = 1'b0;
    out_bit   = 1'b0;
    out_first = 1'b0;
    out_last  = 1'b0;
    case (state_reg)
      DATA: begin
        out_valid = 1'b1;
        out_bit   = shreg_reg[DATA_W-1];
        out_first = first_reg;
      end
      CHECK: begin
        out_valid = 1'b1;
        out_bit   = chk_reg[CHK_W-1];
        out_last  = (cnt_reg == '0);
      end
      default: ;
    endcase
  end

  assign handshake = out_valid && out_ready;

  always_comb begin
    state_next  = state_reg;
    shreg_next  = shreg_reg;
    cnt_next    = cnt_reg;
    chk_next    = chk_reg;
    first_next  = first_reg;
    rem_clr     = 1'b0;
    rem_advance = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          shreg_next = in_data;
          cnt_next   = CNT_W'(DATA_W - 1);
          first_next = 1'b1;
          rem_clr    = 1'b1;
          state_next = DATA;
        end
      end
      DATA: begin
        if (handshake) begin
          rem_advance = 1'b1;
          shreg_next  = shreg_reg << 1;
          first_next  = 1'b0;
          if (cnt_reg == '0) begin
            // The registered remainder lags by the bit being sent now,
            // so fold it in before picking the check value.
            chk_next   = check_bits(next_rem(rem, out_bit));
            cnt_next   = CNT_W'(2);
            state_next = CHECK;
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
      end
      CHECK: begin
        if (handshake) begin
          chk_next = chk_reg << 1;
          if (cnt_reg == '0) begin
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      shreg_reg <= '0;
      cnt_reg   <= '0;
      chk_reg   <= '0;
      first_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      shreg_reg <= shreg_next;
      cnt_reg   <= cnt_next;
      chk_reg   <= chk_next;
      first_reg <= first_next;
    end
  end

`ifdef SERIAL_MOD5_TX_FRAME_CNT_EN
  logic [15:0] frame_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_reg <= '0;
    end else if (out_last && out_ready) begin
      frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_reg;
`endif

endmodule

// File: tb/tb_serial_mod5_check_transmitter.sv
// tb_serial_mod5_check_transmitter
//   Randomized and directed stimulus against an arithmetic frame model:
//   frame = X*8 + C where C = (5 - (X*8) % 5) % 5, sent MSB-first.
//   Optional macro SERIAL_MOD5_TX_FRAME_CNT_EN enables the frame_cnt check.
module tb_serial_mod5_check_transmitter;

  localparam int DW = 8;
  localparam int FW = DW + 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_bit;
  logic          out_first;
  logic          out_last;
`ifdef SERIAL_MOD5_TX_FRAME_CNT_EN
  logic [15:0]   frame_cnt;
`endif

  int errors = 0;
  int checks = 0;

  serial_mod5_check_transmitter #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .out_first (out_first),
    .out_last  (out_last)
`ifdef SERIAL_MOD5_TX_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] frame_of(input logic [DW-1:0] x);
    int c;
    c = (5 - ((int'(x) * 8) % 5)) % 5;
    return {x, c[2:0]};
  endfunction

  // Offer a word once in_ready is seen; returns at #1 after the accepting edge.
  task automatic load_word(input logic [DW-1:0] x, input bit keep_valid);
    int waited = 0;
    while (in_ready !== 1'b1) begin
      if (waited > 50) begin
        checks++; errors++;
        $display("FAIL load_timeout x=%02h in_ready=%b want 1", x, in_ready);
        return;
      end
      @(posedge clk); #1;
      waited++;
    end
    in_valid = 1'b1;
    in_data  = x;
    @(posedge clk); #1;
    if (!keep_valid) in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_first !== 1'b1) begin
      errors++;
      $display("FAIL latency x=%02h out_valid=%b out_first=%b want 1 1", x, out_valid, out_first);
    end
  endtask

  // mode: 0 = always ready, 1 = toggling ready, 2 = random ready
  task automatic collect_frame(input logic [DW-1:0] x, input int mode);
    logic [FW-1:0] f;
    longint        val;
    int            idx;
    int            cycles;
    bit            stalled;
    logic          pb, pf, pl;
    f = frame_of(x);
    val = 0; idx = 0; cycles = 0; stalled = 0;
    pb = 0; pf = 0; pl = 0;
    while (idx < FW) begin
      if (cycles > 400) begin
        checks++; errors++;
        $display("FAIL frame_timeout x=%02h handshakes=%0d want %0d", x, idx, FW);
        out_ready = 1'b0;
        return;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cycles % 2) == 0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL busy_ready x=%02h idx=%0d in_ready=%b want 0", x, idx, in_ready);
      end
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL out_valid x=%02h idx=%0d got=%b want 1", x, idx, out_valid);
      end
      if (stalled) begin
        checks++;
        if (out_bit !== pb || out_first !== pf || out_last !== pl) begin
          errors++;
          $display("FAIL stall_hold x=%02h idx=%0d got=%b%b%b want %b%b%b",
                   x, idx, out_bit, out_first, out_last, pb, pf, pl);
        end
      end
      if (out_ready) begin
        checks++;
        if (out_bit !== f[FW-1-idx] || out_first !== (idx == 0) || out_last !== (idx == FW-1)) begin
          errors++;
          $display("FAIL bit x=%02h idx=%0d bit/first/last=%b%b%b want %b%b%b",
                   x, idx, out_bit, out_first, out_last, f[FW-1-idx], (idx == 0), (idx == FW-1));
        end
        val = val * 2 + longint'(out_bit === 1'b1);
        idx++;
        stalled = 0;
      end else begin
        stalled = 1;
        pb = out_bit; pf = out_first; pl = out_last;
      end
      @(posedge clk); #1;
      cycles++;
    end
    out_ready = 1'b0;
    checks++;
    if (val % 5 != 0 || val != longint'(f)) begin
      errors++;
      $display("FAIL div_by_5 x=%02h received=%0d want %0d (mod 5 == 0)", x, val, f);
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_after x=%02h out_valid=%b in_ready=%b want 0 1", x, out_valid, in_ready);
    end
    $display("frame x=%02h bits=%b cycles=%0d", x, val[FW-1:0], cycles);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_first !== 1'b0 ||
        out_last !== 1'b0 || out_bit !== 1'b0) begin
      errors++;
      $display("FAIL reset_state ready/valid/first/last/bit=%b%b%b%b%b want 00000",
               in_ready, out_valid, out_first, out_last, out_bit);
    end
`ifdef SERIAL_MOD5_TX_FRAME_CNT_EN
    checks++;
    if (frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_frame_cnt got=%0d want 0", frame_cnt);
    end
`endif
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got=%b want 1", in_ready);
    end
  endtask

  task automatic test_fixed();
    logic [DW-1:0] words [3];
    words[0] = 8'd7; words[1] = 8'd0; words[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      load_word(words[i], 1'b0);
      collect_frame(words[i], 0);
    end
  endtask

  task automatic test_stall();
    load_word(8'd13, 1'b0);
    collect_frame(8'd13, 1);
  endtask

  task automatic test_back_to_back();
    load_word(8'h5A, 1'b1);
    in_data = 8'hC3;
    collect_frame(8'h5A, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_first !== 1'b1) begin
      errors++;
      $display("FAIL second_word_accept out_valid=%b out_first=%b want 1 1", out_valid, out_first);
    end
    collect_frame(8'hC3, 0);
  endtask

  task automatic test_abort();
    logic [FW-1:0] f;
    f = frame_of(8'hA7);
    load_word(8'hA7, 1'b0);
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'b1;
      checks++;
      if (out_bit !== f[FW-1-i]) begin
        errors++;
        $display("FAIL abort_bit idx=%0d got=%b want %b", i, out_bit, f[FW-1-i]);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_in_reset got=%b want 0", in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_first !== 1'b0 || out_last !== 1'b0 ||
        out_bit !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_state valid/first/last/bit/ready=%b%b%b%b%b want 00001",
               out_valid, out_first, out_last, out_bit, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL no_check_bits cycle=%0d out_valid=%b want 0", i, out_valid);
      end
    end
    out_ready = 1'b0;
    load_word(8'h3C, 1'b0);
    collect_frame(8'h3C, 0);
  endtask

  task automatic test_random_loopback();
    logic [DW-1:0] x;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      x = DW'($urandom);
      load_word(x, 1'b0);
      collect_frame(x, 2);
    end
`ifdef SERIAL_MOD5_TX_FRAME_CNT_EN
    checks++;
    if (frame_cnt !== 16'd1000) begin
      errors++;
      $display("FAIL frame_cnt got=%0d want 1000", frame_cnt);
    end
`endif
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_fixed();
    test_stall();
    test_back_to_back();
    test_abort();
    test_random_loopback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
